// File: rtl/mem_slave_pkg.sv
// rtl/mem_slave_pkg.sv - shared types and constants for the mem_slave block
package mem_slave_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    // Wide enough for the largest supported wait-state count (15).
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_slave_if.sv
// rtl/mem_slave_if.sv - req/cmd/ack crossbar slave port bundle
interface mem_slave_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic              req_i;
    logic              cmd_i;
    logic [AW-1:0]     addr_i;
    logic [DW-1:0]     wdata_i;
    logic [DW/8-1:0]   be_i;
    logic [DW-1:0]     rdata_o;
    logic              ack_o;
    logic              err_o;

    modport master (
        output req_i, cmd_i, addr_i, wdata_i, be_i,
        input  rdata_o, ack_o, err_o
    );

    modport slave (
        input  req_i, cmd_i, addr_i, wdata_i, be_i,
        output rdata_o, ack_o, err_o
    );
endinterface

// File: rtl/mem_slave_array.sv
// rtl/mem_slave_array.sv - word storage with byte-enabled write and registered read
module mem_slave_array #(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic            re,
    input  logic [IW-1:0]   idx,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] be,
    output logic [DW-1:0]   rdata
);
    logic [DW-1:0] mem [DEPTH];

    // Read data is zero in every cycle without a read so it doubles as the qualified output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            rdata <= re ? mem[idx] : '0;
            if (we) begin
                for (int b = 0; b < DW/8; b++) begin
                    if (be[b]) begin
                        mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
        end
    end
endmodule

// File: rtl/mem_slave.sv
// rtl/mem_slave.sv - addressable memory slave with wait states; MEM_SLAVE_ADDR_ERR_EN enables range errors
module mem_slave
    import mem_slave_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int DEPTH   = 16,
    parameter int LATENCY = 0
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    mem_slave_if.slave    bus
);
    localparam int IW = $clog2(DEPTH);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               cmd_q;
    logic [AW-1:0]      addr_q;
    logic [DW-1:0]      wdata_q;
    logic [DW/8-1:0]    be_q;
    logic               ack_q, err_q;

    logic               idle, enter_ack;
    logic               sel_cmd;
    logic [AW-1:0]      sel_addr;
    logic [DW-1:0]      sel_wdata;
    logic [DW/8-1:0]    sel_be;
    logic [IW-1:0]      idx;
    logic               in_range, range_err;
    logic               we, re;

    // With zero wait states the access happens on the accepting edge, so take the live request.
    assign idle      = (state == IDLE);
    assign sel_cmd   = idle ? bus.cmd_i   : cmd_q;
    assign sel_addr  = idle ? bus.addr_i  : addr_q;
    assign sel_wdata = idle ? bus.wdata_i : wdata_q;
    assign sel_be    = idle ? bus.be_i    : be_q;
    assign idx       = sel_addr[IW-1:0];

`ifdef MEM_SLAVE_ADDR_ERR_EN
    assign in_range  = (sel_addr < AW'(DEPTH));
    assign range_err = !in_range;
`else
    logic addr_hi_unused;
    assign addr_hi_unused = ^sel_addr[AW-1:IW];
    assign in_range  = ({1'b0, idx} < (IW+1)'(DEPTH));
    assign range_err = 1'b0;
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (bus.req_i) begin
                    if (LATENCY > 0) begin
                        state_next = WAIT;
                        cnt_next   = CNT_W'(LATENCY - 1);
                    end else begin
                        state_next = ACK;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = ACK;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign enter_ack = (state_next == ACK);
    assign we = enter_ack && (sel_cmd == CMD_WRITE) && in_range;
    assign re = enter_ack && (sel_cmd == CMD_READ)  && in_range;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state   <= IDLE;
            cnt     <= '0;
            cmd_q   <= CMD_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ack_q <= enter_ack;
            err_q <= enter_ack && range_err;
            if (idle && bus.req_i) begin
                cmd_q   <= bus.cmd_i;
                addr_q  <= bus.addr_i;
                wdata_q <= bus.wdata_i;
                be_q    <= bus.be_i;
            end
        end
    end

    mem_slave_array #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_array (
        .clk   (clk_i),
        .rst_n (reset_ni),
        .we    (we),
        .re    (re),
        .idx   (idx),
        .wdata (sel_wdata),
        .be    (sel_be),
        .rdata (bus.rdata_o)
    );

    assign bus.ack_o = ack_q;
    assign bus.err_o = err_q;
endmodule

// File: tb/tb_mem_slave.sv
// tb/tb_mem_slave.sv - scoreboard bench for mem_slave at LATENCY 0, 3 and 5
module tb_mem_slave;
    import mem_slave_pkg::*;

    typedef struct {
        int          due;
        logic [31:0] rd;
        logic        chk_rd;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic [2:0]  req, cmd, ack, err, ack_prev;
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  be    [3];
    logic [31:0] rdata [3];
    exp_t        q [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_slave_if #(.DW(32), .AW(32)) bus ();
        assign bus.req_i   = req[g];
        assign bus.cmd_i   = cmd[g];
        assign bus.addr_i  = addr[g];
        assign bus.wdata_i = wdata[g];
        assign bus.be_i    = be[g];
        assign ack[g]      = bus.ack_o;
        assign err[g]      = bus.err_o;
        assign rdata[g]    = bus.rdata_o;

        mem_slave #(
            .DW(32), .AW(32), .DEPTH(16),
            .LATENCY((g == 0) ? 0 : (g == 1) ? 3 : 5)
        ) dut (
            .clk_i    (clk),
            .reset_ni (rst_n),
            .bus      (bus.slave)
        );
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 0 : (i == 1) ? 3 : 5;
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst%0d cycle %0d: got %h want %h", nm, i, cyc, act, exp);
        end
    endtask

    // Monitor: every ack pops one expected entry; an entry left past its due cycle is a timeout.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                chk("rst_ack", i, 32'(ack[i]), 32'd0);
                chk("rst_err", i, 32'(err[i]), 32'd0);
                chk("rst_rdata", i, rdata[i], 32'd0);
            end else if (ack[i]) begin
                chk("ack_pulse", i, 32'(ack_prev[i]), 32'd0);
                if (q[i].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ack inst%0d: got ack at cycle %0d want none", i, cyc);
                end else begin
                    e = q[i].pop_front();
                    chk("ack_cycle", i, cyc, e.due);
                    if (e.chk_rd) chk("rdata", i, rdata[i], e.rd);
                    chk("err", i, 32'(err[i]), 32'(e.err));
                end
            end else if (q[i].size() != 0 && cyc > q[i][0].due) begin
                total++;
                bad++;
                $display("FAIL ack_timeout inst%0d: got no ack by cycle %0d want ack at %0d", i, cyc, q[i][0].due);
                void'(q[i].pop_front());
            end
            ack_prev[i] = ack[i];
        end
    end

    task automatic xact(input int i, input logic c, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] b, input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        int   n;
        @(negedge clk);
        req[i] = 1'b1; cmd[i] = c; addr[i] = a; wdata[i] = wd; be[i] = b;
        e.due = cyc + 1 + lat_of(i);
        e.rd = exp_rd;
        e.chk_rd = (c == CMD_READ);
        e.err = exp_err;
        q[i].push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[i] && n < 40);
        req[i] = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   k;
        rst_n = 1'b0;
        ack_prev = '0;
        req = '0;
        cmd = '0;
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0; wdata[i] = '0; be[i] = '0;
        end
        repeat (4) @(negedge clk);
        rst_n = 1'b1;

        for (int a = 0; a < 16; a++) xact(0, CMD_READ, a, 0, 4'h0, 32'h0, 1'b0);

        xact(0, CMD_WRITE, 3, 32'hDEADBEEF, 4'hF, 0, 1'b0);
        xact(0, CMD_READ,  3, 0, 4'h0, 32'hDEADBEEF, 1'b0);

        xact(0, CMD_WRITE, 5, 32'hAABBCCDD, 4'hF, 0, 1'b0);
        xact(0, CMD_WRITE, 5, 32'h11223344, 4'h5, 0, 1'b0);
        xact(0, CMD_READ,  5, 0, 4'h0, 32'hAA22CC44, 1'b0);
        xact(0, CMD_WRITE, 5, 32'hFFFFFFFF, 4'h0, 0, 1'b0);
        xact(0, CMD_READ,  5, 0, 4'h0, 32'hAA22CC44, 1'b0);

        xact(1, CMD_WRITE, 2, 32'h0BADF00D, 4'hF, 0, 1'b0);
        xact(1, CMD_READ,  2, 0, 4'h0, 32'h0BADF00D, 1'b0);

        // Request held through the ack: second ack follows LATENCY+2 cycles later.
        @(negedge clk);
        req[1] = 1'b1; cmd[1] = CMD_READ; addr[1] = 2;
        k = cyc + 1;
        e.rd = 32'h0BADF00D; e.chk_rd = 1'b1; e.err = 1'b0;
        e.due = k + 3; q[1].push_back(e);
        e.due = k + 8; q[1].push_back(e);
        while (cyc < k + 8) @(negedge clk);
        req[1] = 1'b0;

`ifdef MEM_SLAVE_ADDR_ERR_EN
        xact(0, CMD_WRITE, 16, 32'h1, 4'hF, 0, 1'b1);
        xact(0, CMD_READ,  16, 0, 4'h0, 32'h0, 1'b1);
        xact(0, CMD_READ,  0,  0, 4'h0, 32'h0, 1'b0);
`else
        xact(0, CMD_WRITE, 17, 32'h12345678, 4'hF, 0, 1'b0);
        xact(0, CMD_READ,  1,  0, 4'h0, 32'h12345678, 1'b0);
        xact(0, CMD_READ,  17, 0, 4'h0, 32'h12345678, 1'b0);
`endif

        // Write dropped by reset while in WAIT: no ack ever and the word stays 0.
        @(negedge clk);
        req[2] = 1'b1; cmd[2] = CMD_WRITE; addr[2] = 7; wdata[2] = 32'h55; be[2] = 4'hF;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        req[2] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        xact(2, CMD_READ, 7, 0, 4'h0, 32'h0, 1'b0);
        xact(0, CMD_READ, 3, 0, 4'h0, 32'h0, 1'b0);

        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
